// File: rtl/mag_latch_driver.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : mag_latch_driver
// Purpose  : Command sequencer for the magnetron SR latch. Converts START /
//            STOP_CLEAR edges plus door and timer levels into width-controlled,
//            mutually exclusive S and R pulses with guard spacing, and keeps a
//            shadow copy of the latch state.
// Ports    : CLK          system clock (rising edge)
//            RST_N        synchronous active-low reset
//            START        start request (rising-edge sensitive)
//            STOP_CLEAR   stop request (rising-edge sensitive)
//            DOOR_CLOSED  level, 1 = door closed
//            TIMER_DONE   level, 1 = cook time expired
//            Q_FB         latch Q readback   (MAG_LATCH_READBACK_EN only)
//            FAULT        sticky readback fault (MAG_LATCH_READBACK_EN only)
//            S / R        registered set / reset pulses to the latch
//            MAG_ON       shadow latch state
//            BUSY         high while SETTING, RESETTING or GUARD
// Options  : define MAG_LATCH_READBACK_EN to add the Q_FB readback check.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module mag_latch_driver #(
   parameter int PULSE_W = 2,
   parameter int GUARD_W = 4
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic START,
   input  logic STOP_CLEAR,
   input  logic DOOR_CLOSED,
   input  logic TIMER_DONE,
`ifdef MAG_LATCH_READBACK_EN
   input  logic Q_FB,
   output logic FAULT,
`endif
   output logic S,
   output logic R,
   output logic MAG_ON,
   output logic BUSY
);

   generate
      if (PULSE_W < 1 || PULSE_W > 15) begin : g_bad_pulse_w
         $error("mag_latch_driver: PULSE_W must be in 1..15");
      end
      if (GUARD_W < 1 || GUARD_W > 15) begin : g_bad_guard_w
         $error("mag_latch_driver: GUARD_W must be in 1..15");
      end
   endgenerate

   localparam logic [3:0] PULSE_LAST = 4'(PULSE_W - 1);
   localparam logic [3:0] GUARD_LAST = 4'(GUARD_W - 1);

   typedef enum logic [2:0] {
      ST_OFF       = 3'd0,
      ST_SETTING   = 3'd1,
      ST_ON        = 3'd2,
      ST_RESETTING = 3'd3,
      ST_GUARD     = 3'd4
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic       start_d;
   logic       stop_d;
   logic [3:0] cnt;        // cycles spent in the current state, saturating
   logic       ret_on;     // GUARD returns to ON (1) or OFF (0)
   logic       kill_pend;  // stop edge seen while turning on, served after GUARD

   logic start_rise;
   logic stop_rise;
   logic kill;
   logic pulse_last;
   logic guard_last;
   logic fb_bad;
   logic fault_q;

   assign start_rise = START & ~start_d;
   assign stop_rise  = STOP_CLEAR & ~stop_d;
   assign kill       = stop_rise | ~DOOR_CLOSED | TIMER_DONE;
   assign pulse_last = (cnt >= PULSE_LAST);
   assign guard_last = (cnt >= GUARD_LAST);

`ifdef MAG_LATCH_READBACK_EN
   assign fb_bad = (state == ST_GUARD) && guard_last && (Q_FB != MAG_ON);
   assign FAULT  = fault_q;
`else
   assign fb_bad = 1'b0;
`endif

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_OFF: begin
            if (start_rise && DOOR_CLOSED && !TIMER_DONE && !stop_rise && !fault_q)
               state_nxt = ST_SETTING;
         end
         ST_SETTING: begin
            if (pulse_last)
               state_nxt = ST_GUARD;
         end
         ST_ON: begin
            if (kill)
               state_nxt = ST_RESETTING;
         end
         ST_RESETTING: begin
            if (pulse_last)
               state_nxt = ST_GUARD;
         end
         ST_GUARD: begin
            if (guard_last) begin
               if (fb_bad)
                  state_nxt = MAG_ON ? ST_RESETTING : ST_OFF;
               else if (ret_on)
                  state_nxt = (kill || kill_pend) ? ST_RESETTING : ST_ON;
               else
                  state_nxt = ST_OFF;
            end
         end
         default: state_nxt = ST_OFF;
      endcase
   end

   // State, counters and registered outputs. S/R/BUSY are decoded from the
   // next state so they line up with the state they belong to and never glitch.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state     <= ST_OFF;
         start_d   <= 1'b0;
         stop_d    <= 1'b0;
         cnt       <= 4'd0;
         ret_on    <= 1'b0;
         kill_pend <= 1'b0;
         fault_q   <= 1'b0;
         S         <= 1'b0;
         R         <= 1'b0;
         MAG_ON    <= 1'b0;
         BUSY      <= 1'b0;
      end else begin
         state   <= state_nxt;
         start_d <= START;
         stop_d  <= STOP_CLEAR;

         if (state_nxt != state)
            cnt <= 4'd0;
         else if (cnt != 4'hF)
            cnt <= cnt + 4'd1;

         S    <= (state_nxt == ST_SETTING);
         R    <= (state_nxt == ST_RESETTING);
         BUSY <= (state_nxt == ST_SETTING) || (state_nxt == ST_RESETTING) ||
                 (state_nxt == ST_GUARD);

         if (state == ST_SETTING && pulse_last)
            MAG_ON <= 1'b1;
         else if (state == ST_RESETTING && pulse_last)
            MAG_ON <= 1'b0;

         if (state == ST_SETTING)
            ret_on <= 1'b1;
         else if (state == ST_RESETTING)
            ret_on <= 1'b0;

         // A stop edge during an ON transition must not be lost: the S pulse
         // runs to completion, so remember the stop and act after GUARD.
         if (state_nxt == ST_RESETTING || state_nxt == ST_OFF)
            kill_pend <= 1'b0;
         else if (stop_rise && (state == ST_SETTING || (state == ST_GUARD && ret_on)))
            kill_pend <= 1'b1;

         if (fb_bad)
            fault_q <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: doc/mag_latch_driver.md
Name: mag_latch_driver

Overview:
Command sequencer for the magnetron SR latch in the Mag_Control level. It turns the START, STOP_CLEAR, door and timer inputs into clean, width-controlled S and R pulses. S and R are never asserted together. Guard spacing is enforced between opposite commands. The block keeps a shadow copy of the latch state (MAG_ON) for the upper control levels.

Parameters:
PULSE_W, 2, cycles that S or R is held high per command (range 1..15)
GUARD_W, 4, minimum idle cycles after any pulse before the next command is accepted (range 1..15)

Ports:
CLK  input  1  system clock, all logic on rising edge
RST_N  input  1  synchronous active-low reset, sampled on CLK rising edge
START  input  1  start request, rising-edge sensitive
STOP_CLEAR  input  1  stop request, rising-edge sensitive
DOOR_CLOSED  input  1  level; 1 = door closed
TIMER_DONE  input  1  level; 1 = cook time expired
S  output  1  set pulse to latch
R  output  1  reset pulse to latch
MAG_ON  output  1  shadow latch state
BUSY  output  1  high in SETTING, RESETTING, GUARD

Behaviour:
- Reset (RST_N=0 at CLK edge): state=OFF, S=0, R=0, MAG_ON=0, BUSY=0, edge registers cleared. Counters are cleared, and reset mid-pulse drops S/R on the same edge.
- Edge detect: start_rise = START & ~START_d and stop_rise = STOP_CLEAR & ~STOP_CLEAR_d. The _d registers update every cycle, including when busy. A rise seen while BUSY is discarded; it is not queued.
- kill = stop_rise | ~DOOR_CLOSED | TIMER_DONE (level terms are evaluated every cycle).
- States:
  - OFF: if start_rise & DOOR_CLOSED & ~TIMER_DONE & ~stop_rise, go to SETTING. Otherwise stay in OFF, with no pulse on R.
  - SETTING: S=1 for exactly PULSE_W cycles. On the last cycle set MAG_ON=1, then go to GUARD (ret=ON).
  - ON: if kill, go to RESETTING. start_rise is ignored.
  - RESETTING: R=1 for exactly PULSE_W cycles. On the last cycle set MAG_ON=0, then go to GUARD (ret=OFF).
  - GUARD: S=R=0 for GUARD_W cycles, then go to ret. If ret=ON and kill is true on the exit cycle, go directly to RESETTING.
- Latency: start_rise in cycle n gives S=1 from cycle n+1 to n+PULSE_W, and MAG_ON=1 from cycle n+PULSE_W+1.
- Kill during SETTING: the pulse completes without truncation. GUARD follows, then the deferred kill causes RESETTING.
- Invariant: S & R is never 1. S/R are registered outputs with no glitches.
- Counters are 4-bit and saturate at their terminal count. PULSE_W=0 or GUARD_W=0 is illegal (checked at elaboration with $error under simulation).
- start_rise and stop_rise in the same cycle in OFF: stop wins, and no pulse is issued.

Optional Feature:
Macro MAG_LATCH_READBACK_EN.
- Defined:
  - Adds input Q_FB (latch Q) and output FAULT (1 bit, reset 0).
  - On the last GUARD cycle, Q_FB must equal MAG_ON. Otherwise FAULT=1 (sticky until RST_N), and the next state is RESETTING if MAG_ON=1, else OFF.
  - While FAULT=1, start_rise is ignored.
- Undefined: no Q_FB/FAULT ports, and no readback check.

Test Plan:
1. Reset then idle: RST_N=0 for 3 cycles, then 1. S=R=MAG_ON=BUSY=0 for 10 cycles.
2. Normal start (defaults): DOOR_CLOSED=1, START rises at cycle 5. S=1 in cycles 6–7, MAG_ON=1 from cycle 8, BUSY=0 from cycle 12, R=0 throughout.
3. Door open while ON: DOOR_CLOSED falls at cycle 20. R=1 in cycles 21–22, MAG_ON=0 from cycle 23, state OFF after cycle 26.
4. Start with door open: DOOR_CLOSED=0, START pulses. No S pulse, and MAG_ON stays 0. A START rise during GUARD is discarded, with no second S pulse.
5. Kill during SETTING: STOP_CLEAR rises in the first S cycle. S still lasts 2 cycles, then 4 guard cycles, then R lasts 2 cycles. S and R never overlap (assert every cycle).
6. With MAG_LATCH_READBACK_EN: Q_FB held 0 through a start sequence. FAULT=1 at the end of guard, R pulses 2 cycles, MAG_ON=0, and later START rises produce no S.
